// File: rtl/spi_bus_initiator.sv
// SPI mode-0 slave front end. Oversamples the host SPI pins on the system
// clock, decodes a two-byte frame {rw, msel[1:0], ioc[4:0]} + data, and
// issues exactly one fetch or load strobe to one of four register modules.
// Read data for the selected module is returned on MISO during byte 1.
//
// Handshake: o_fetch_cmd / o_load_cmd are single-cycle strobes; o_cs, o_ioc
// (and o_data_out for loads) are already stable in the cycle the strobe is
// high and stay stable for that whole cycle. There is no back-pressure.
module spi_bus_initiator #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_sys_clk,
  input  logic        i_reset,
  input  logic        i_spi_sck,
  input  logic        i_spi_mosi,
  input  logic        i_spi_cs_n,
  output logic        o_spi_miso,
  output logic [4:0]  o_ioc,
  output logic [7:0]  o_data_out,
  output logic [3:0]  o_cs,
  output logic        o_fetch_cmd,
  output logic        o_load_cmd,
  input  logic [31:0] i_data_in
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_FETCH   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_DATA    = 3'd5,
    ST_LOAD    = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  state_t state;

  // Synchroniser chains; the last stage is the synchronised sample.
  logic [SYNC_STAGES-1:0] sck_sr;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic [SYNC_STAGES-1:0] cs_sr;
  logic                   sck_prev;
  logic                   cs_prev;
  // Fills with ones after reset; once full, sync and prev hold real pin
  // samples rather than reset values, so a CS_n held low through reset is
  // never mistaken for a fresh falling edge.
  logic [SYNC_STAGES:0]   valid_sr;

  logic sck_sync;
  logic mosi_sync;
  logic cs_sync;
  logic sync_ok;
  logic sck_rise;
  logic sck_fall;
  logic cs_fall;

  assign sck_sync  = sck_sr[SYNC_STAGES-1];
  assign mosi_sync = mosi_sr[SYNC_STAGES-1];
  assign cs_sync   = cs_sr[SYNC_STAGES-1];
  assign sync_ok   = valid_sr[SYNC_STAGES];
  assign sck_rise  = sck_sync & ~sck_prev;
  assign sck_fall  = ~sck_sync & sck_prev;
  assign cs_fall   = sync_ok & cs_prev & ~cs_sync;

  // Frame datapath registers
  logic [6:0] rx_shift;
  logic [6:0] tx_shift;
  logic [3:0] bit_cnt;
  logic       rw;
  logic [1:0] msel;
  logic       skip_fall;

  logic [7:0] rx_next;
  logic [7:0] rd_byte;

  assign rx_next = {rx_shift, mosi_sync};
  assign rd_byte = i_data_in[{msel, 3'b000} +: 8];

  // Pin synchronisers and edge-detect history
  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      sck_sr   <= '0;
      mosi_sr  <= '0;
      cs_sr    <= '1;
      sck_prev <= 1'b0;
      cs_prev  <= 1'b1;
      valid_sr <= '0;
    end else begin
      sck_sr   <= {sck_sr[SYNC_STAGES-2:0], i_spi_sck};
      mosi_sr  <= {mosi_sr[SYNC_STAGES-2:0], i_spi_mosi};
      cs_sr    <= {cs_sr[SYNC_STAGES-2:0], i_spi_cs_n};
      sck_prev <= sck_sync;
      cs_prev  <= cs_sync;
      valid_sr <= {valid_sr[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Frame FSM with registered bus strobes, selects and MISO
  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      o_spi_miso  <= 1'b0;
      o_ioc       <= '0;
      o_data_out  <= '0;
      o_cs        <= '0;
      o_fetch_cmd <= 1'b0;
      o_load_cmd  <= 1'b0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      bit_cnt     <= '0;
      rw          <= 1'b0;
      msel        <= '0;
      skip_fall   <= 1'b0;
    end else begin
      o_fetch_cmd <= 1'b0;
      o_load_cmd  <= 1'b0;
      case (state)
        ST_IDLE: begin
          bit_cnt    <= '0;
          o_cs       <= '0;
          o_spi_miso <= 1'b0;
          skip_fall  <= 1'b0;
          if (cs_fall) begin
            rx_shift <= '0;
            state    <= ST_CMD;
          end
        end

        ST_CMD: begin
          if (cs_sync) begin
            state      <= ST_IDLE;
            o_cs       <= '0;
            bit_cnt    <= '0;
            o_spi_miso <= 1'b0;
          end else if (sck_rise) begin
            rx_shift <= rx_next[6:0];
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              o_ioc     <= rx_next[4:0];
              o_cs      <= 4'b0001 << rx_next[6:5];
              msel      <= rx_next[6:5];
              rw        <= rx_next[7];
              skip_fall <= 1'b1;
              if (rx_next[7]) begin
                o_fetch_cmd <= 1'b1;
                state       <= ST_FETCH;
              end else begin
                state <= ST_DATA;
              end
            end
          end
        end

        ST_FETCH, ST_WAIT: begin
          if (cs_sync) begin
            state      <= ST_IDLE;
            o_cs       <= '0;
            bit_cnt    <= '0;
            o_spi_miso <= 1'b0;
          end else begin
            state <= (state == ST_FETCH) ? ST_WAIT : ST_CAPTURE;
          end
        end

        ST_CAPTURE: begin
          if (cs_sync) begin
            state      <= ST_IDLE;
            o_cs       <= '0;
            bit_cnt    <= '0;
            o_spi_miso <= 1'b0;
          end else begin
            tx_shift   <= rd_byte[6:0];
            o_spi_miso <= rd_byte[7];
            state      <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (cs_sync) begin
            state      <= ST_IDLE;
            o_cs       <= '0;
            bit_cnt    <= '0;
            o_spi_miso <= 1'b0;
          end else begin
            if (sck_rise) begin
              rx_shift <= rx_next[6:0];
              bit_cnt  <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd15) begin
                o_spi_miso <= 1'b0;
                if (rw) begin
                  state <= ST_DONE;
                end else begin
                  o_data_out <= rx_next;
                  o_load_cmd <= 1'b1;
                  state      <= ST_LOAD;
                end
              end
            end
            // The fall right after the command byte belongs to bit 7,
            // which was already presented by CAPTURE.
            if (sck_fall) begin
              if (skip_fall) begin
                skip_fall <= 1'b0;
              end else if (rw) begin
                o_spi_miso <= tx_shift[6];
                tx_shift   <= {tx_shift[5:0], 1'b0};
              end
            end
          end
        end

        ST_LOAD: begin
          o_spi_miso <= 1'b0;
          state      <= ST_DONE;
        end

        ST_DONE: begin
          o_spi_miso <= 1'b0;
          if (cs_sync) begin
            state   <= ST_IDLE;
            o_cs    <= '0;
            bit_cnt <= '0;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bus_initiator.sv
// Bench for spi_bus_initiator: table of complete frames with hand-computed
// strobes/selects/MISO bytes, plus sequences for abort and mid-frame reset.
module tb_spi_bus_initiator;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 8;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sck;
  logic        mosi;
  logic        cs_n;
  logic        miso;
  logic [4:0]  ioc;
  logic [7:0]  data_out;
  logic [3:0]  cs;
  logic        fetch;
  logic        load;
  logic [31:0] din;

  spi_bus_initiator #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .i_sys_clk   (clk),
    .i_reset     (rst),
    .i_spi_sck   (sck),
    .i_spi_mosi  (mosi),
    .i_spi_cs_n  (cs_n),
    .o_spi_miso  (miso),
    .o_ioc       (ioc),
    .o_data_out  (data_out),
    .o_cs        (cs),
    .o_fetch_cmd (fetch),
    .o_load_cmd  (load),
    .i_data_in   (din)
  );

  // Scoreboard counters
  int checks = 0;
  int errors = 0;

  // Strobe monitor: counts high cycles and captures bus state at each strobe
  int         fetch_cnt = 0;
  int         load_cnt  = 0;
  int         both_cnt  = 0;
  logic [3:0] fetch_cs  = '0;
  logic [4:0] fetch_ioc = '0;
  logic [3:0] load_cs   = '0;
  logic [4:0] load_ioc  = '0;
  logic [7:0] load_data = '0;

  always @(negedge clk) begin
    if (fetch) begin
      fetch_cnt = fetch_cnt + 1;
      fetch_cs  = cs;
      fetch_ioc = ioc;
    end
    if (load) begin
      load_cnt  = load_cnt + 1;
      load_cs   = cs;
      load_ioc  = ioc;
      load_data = data_out;
    end
    if (fetch && load) both_cnt = both_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Driver: clocks bits [first,last) of a frame; bits past 16 alternate.
  // MISO is sampled just before each byte-1 rising edge, as a host would.
  task automatic send_bits(input logic [15:0] frame, input int first, input int last,
                           output logic [7:0] miso_byte);
    miso_byte = '0;
    for (int i = first; i < last; i++) begin
      if (i < 16) mosi = frame[15-i];
      else        mosi = i[0];
      cyc(HALF);
      if (i >= 8 && i < 16) miso_byte[15-i] = miso;
      sck = 1'b1;
      cyc(HALF);
      sck = 1'b0;
    end
  endtask

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [31:0] din;
    int          nbits;
    int          exp_fetch;
    int          exp_load;
    logic [3:0]  exp_cs;
    logic [4:0]  exp_ioc;
    logic [7:0]  exp_data;
    logic [7:0]  exp_miso;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [7:0] mb;
    int f0, l0, n;

    vecs[0] = '{8'h42, 8'h05, 32'h0000_0000, 16, 0, 1, 4'b0100, 5'd2,  8'h05, 8'h00};
    vecs[1] = '{8'h80, 8'h5A, 32'hA53C_017E, 16, 1, 0, 4'b0001, 5'd0,  8'h00, 8'h7E};
    vecs[2] = '{8'hE5, 8'hFF, 32'hA53C_017E, 16, 1, 0, 4'b1000, 5'd5,  8'h00, 8'hA5};
    vecs[3] = '{8'h23, 8'hFF, 32'h0000_0000, 24, 0, 1, 4'b0010, 5'd3,  8'hFF, 8'h00};
    vecs[4] = '{8'hA1, 8'h00, 32'hA53C_017E, 16, 1, 0, 4'b0010, 5'd1,  8'h00, 8'h01};
    vecs[5] = '{8'h7F, 8'hA5, 32'hFFFF_FFFF, 16, 0, 1, 4'b1000, 5'd31, 8'hA5, 8'h00};
    vecs[6] = '{8'hC0, 8'h81, 32'h1234_5678, 24, 1, 0, 4'b0100, 5'd0,  8'h00, 8'h34};

    rst = 1'b1; sck = 1'b0; mosi = 1'b0; cs_n = 1'b1; din = '0;
    cyc(4);
    check("reset_cs",    32'(cs),       32'h0);
    check("reset_ioc",   32'(ioc),      32'h0);
    check("reset_data",  32'(data_out), 32'h0);
    check("reset_miso",  32'(miso),     32'h0);
    check("reset_fetch", 32'(fetch),    32'h0);
    check("reset_load",  32'(load),     32'h0);
    rst = 1'b0;
    cyc(10);

    // Table-driven complete frames
    for (int v = 0; v < 7; v++) begin
      din  = vecs[v].din;
      f0   = fetch_cnt;
      l0   = load_cnt;
      cs_n = 1'b0;
      cyc(HALF);
      send_bits({vecs[v].b0, vecs[v].b1}, 0, vecs[v].nbits, mb);
      cyc(HALF);
      check($sformatf("v%0d_cs_in_frame", v), 32'(cs), 32'(vecs[v].exp_cs));
      cs_n = 1'b1;
      cyc(12);
      check($sformatf("v%0d_fetch_pulses", v), 32'(fetch_cnt - f0), 32'(vecs[v].exp_fetch));
      check($sformatf("v%0d_load_pulses", v),  32'(load_cnt - l0),  32'(vecs[v].exp_load));
      check($sformatf("v%0d_miso_byte", v),    32'(mb),             32'(vecs[v].exp_miso));
      check($sformatf("v%0d_cs_after", v),     32'(cs),             32'h0);
      check($sformatf("v%0d_ioc_hold", v),     32'(ioc),            32'(vecs[v].exp_ioc));
      if (vecs[v].exp_fetch != 0) begin
        check($sformatf("v%0d_fetch_cs", v),  32'(fetch_cs),  32'(vecs[v].exp_cs));
        check($sformatf("v%0d_fetch_ioc", v), 32'(fetch_ioc), 32'(vecs[v].exp_ioc));
      end
      if (vecs[v].exp_load != 0) begin
        check($sformatf("v%0d_load_cs", v),   32'(load_cs),   32'(vecs[v].exp_cs));
        check($sformatf("v%0d_load_ioc", v),  32'(load_ioc),  32'(vecs[v].exp_ioc));
        check($sformatf("v%0d_load_data", v), 32'(load_data), 32'(vecs[v].exp_data));
        check($sformatf("v%0d_data_hold", v), 32'(data_out),  32'(vecs[v].exp_data));
      end
    end

    // Abort: CS_n raised after 12 bits of a write
    f0 = fetch_cnt;
    l0 = load_cnt;
    cs_n = 1'b0;
    cyc(HALF);
    send_bits(16'h42AA, 0, 12, mb);
    cyc(HALF);
    check("abort_cs_mid", 32'(cs), 32'h4);
    cs_n = 1'b1;
    n = 0;
    while (cs != 4'h0 && n < 20) begin
      cyc(1);
      n++;
    end
    check("abort_cs_cleared", 32'(cs), 32'h0);
    check("abort_latency_ok", 32'(n <= SYNC_STAGES + 2), 32'h1);
    cyc(12);
    check("abort_no_load",  32'(load_cnt - l0),  32'h0);
    check("abort_no_fetch", 32'(fetch_cnt - f0), 32'h0);

    // Recovery write after abort
    l0 = load_cnt;
    cs_n = 1'b0;
    cyc(HALF);
    send_bits(16'h011C, 0, 16, mb);
    cyc(HALF);
    cs_n = 1'b1;
    cyc(12);
    check("post_abort_load",     32'(load_cnt - l0), 32'h1);
    check("post_abort_data",     32'(load_data),     32'h1C);
    check("post_abort_load_cs",  32'(load_cs),       32'h1);
    check("post_abort_load_ioc", 32'(load_ioc),      32'h1);

    // Reset in the data phase of a write, frame then continues with CS_n low
    f0 = fetch_cnt;
    l0 = load_cnt;
    cs_n = 1'b0;
    cyc(HALF);
    send_bits(16'h5E99, 0, 12, mb);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    check("midrst_cs",   32'(cs),       32'h0);
    check("midrst_ioc",  32'(ioc),      32'h0);
    check("midrst_data", 32'(data_out), 32'h0);
    check("midrst_miso", 32'(miso),     32'h0);
    send_bits(16'h5E99, 12, 16, mb);
    send_bits(16'h5E99, 0, 16, mb);
    cyc(HALF);
    check("midrst_no_load",  32'(load_cnt - l0),  32'h0);
    check("midrst_no_fetch", 32'(fetch_cnt - f0), 32'h0);
    check("midrst_cs_idle",  32'(cs),             32'h0);
    cs_n = 1'b1;
    cyc(12);

    // Recovery read after mid-frame reset
    din = 32'hA53C_017E;
    f0 = fetch_cnt;
    cs_n = 1'b0;
    cyc(HALF);
    send_bits(16'hA100, 0, 16, mb);
    cyc(HALF);
    cs_n = 1'b1;
    cyc(12);
    check("post_rst_fetch",    32'(fetch_cnt - f0), 32'h1);
    check("post_rst_miso",     32'(mb),             32'h01);
    check("post_rst_fetch_cs", 32'(fetch_cs),       32'h2);

    check("fetch_load_overlap", 32'(both_cnt), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
